// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: register addressing and register-bank reset modes.
package mips32_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t R0 = '0;

   // Register-bank reset contents
   localparam int unsigned INIT_ZERO  = 0;
   localparam int unsigned INIT_INDEX = 1;

endpackage

// File: rtl/mips32_regbank_sb_if.sv
// ID/WB-facing bus of the scoreboarded register bank.
interface mips32_regbank_sb_if #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned RD_PORTS = 2
);
   localparam int unsigned AW = $clog2(NUM_REGS);

   logic [RD_PORTS*AW-1:0]     rs_addr;
   logic [RD_PORTS*DATA_W-1:0] rs_data;
   logic                       issue_valid;
   logic                       issue_rd_en;
   logic [AW-1:0]              issue_rd;
   logic                       stall;
   logic                       wb_valid;
   logic [AW-1:0]              wb_rd;
   logic [DATA_W-1:0]          wb_data;
   logic                       flush;
   logic [NUM_REGS-1:0]        busy_vec;
   logic                       sb_err;

   modport master (
      output rs_addr, issue_valid, issue_rd_en, issue_rd, wb_valid, wb_rd, wb_data, flush,
      input  rs_data, stall, busy_vec, sb_err
   );

   modport slave (
      input  rs_addr, issue_valid, issue_rd_en, issue_rd, wb_valid, wb_rd, wb_data, flush,
      output rs_data, stall, busy_vec, sb_err
   );

endinterface

// File: rtl/mips32_regbank_sb_counter.sv
// Per-register pending-write counter; saturates at both ends, clr has priority.
module sb_counter #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             full,
   output logic             one
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !dec && cnt != CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end else if (dec && !inc && cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign full = (cnt == CNT_MAX);
   assign one  = (cnt == CNT_W'(1));

endmodule

// File: rtl/mips32_regbank_sb.sv
// Register bank with write-pending scoreboard and WB->ID bypass; lets dependent
// instructions issue back-to-back, stalling only on unresolved sources or a full counter.
module mips32_regbank_sb
   import mips32_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned RD_PORTS  = 2,
   parameter int unsigned CNT_W     = 2,
   parameter int unsigned INIT_MODE = 0
) (
   input logic                 clk,
   input logic                 reset,
   mips32_regbank_sb_if.slave  bus
);
   localparam int unsigned AW = $clog2(NUM_REGS);
   localparam logic [AW-1:0] RZ = AW'(R0);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [CNT_W-1:0]    cnt  [NUM_REGS];
   logic [NUM_REGS-1:0] busy_c;
   logic [NUM_REGS-1:0] full_v;
   logic [NUM_REGS-1:0] one_v;
   logic [RD_PORTS-1:0] src_haz;
   logic                dst_haz;
   logic                stall_c;
   logic                accept;
   logic                wb_nz;
   logic                wb_we;
   logic                wb_dec;
   logic                wb_err;

   // Writeback qualification; during flush the data write ignores the counter
   always_comb begin
      wb_nz  = bus.wb_valid && (bus.wb_rd != RZ);
      wb_dec = wb_nz && busy_c[bus.wb_rd] && !bus.flush;
      wb_we  = wb_nz && (busy_c[bus.wb_rd] || bus.flush);
      wb_err = wb_nz && !busy_c[bus.wb_rd] && !bus.flush;
   end

   // Hazard detection: a source resolves if its single pending write lands this cycle
   always_comb begin
      logic [AW-1:0] a;
      src_haz = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
         a = bus.rs_addr[p*AW +: AW];
         src_haz[p] = (a != RZ) && busy_c[a] &&
                      !(bus.wb_valid && (bus.wb_rd == a) && one_v[a]);
      end
      dst_haz = bus.issue_rd_en && (bus.issue_rd != RZ) && full_v[bus.issue_rd] &&
                !(bus.wb_valid && (bus.wb_rd == bus.issue_rd));
      stall_c = bus.issue_valid && ((|src_haz) || dst_haz);
      accept  = bus.issue_valid && !stall_c && bus.issue_rd_en &&
                (bus.issue_rd != RZ) && !bus.flush;
   end

   assign bus.stall = stall_c;

   // Read ports with writeback bypass
   always_comb begin
      logic [AW-1:0] a;
      bus.rs_data = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
         a = bus.rs_addr[p*AW +: AW];
         if (a == RZ) begin
            bus.rs_data[p*DATA_W +: DATA_W] = '0;
         end else if (bus.wb_valid && (bus.wb_rd == a)) begin
            bus.rs_data[p*DATA_W +: DATA_W] = bus.wb_data;
         end else begin
            bus.rs_data[p*DATA_W +: DATA_W] = regs[a];
         end
      end
   end

   generate
      for (genvar k = 0; k < NUM_REGS; k++) begin : g_cnt
         sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (accept && (bus.issue_rd == AW'(k))),
            .dec   (wb_dec && (bus.wb_rd == AW'(k))),
            .clr   (bus.flush),
            .cnt   (cnt[k]),
            .full  (full_v[k]),
            .one   (one_v[k])
         );
         assign busy_c[k] = (cnt[k] != '0);
      end
   endgenerate

   assign bus.busy_vec = busy_c;

   // Storage; R0 only ever takes its reset value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs[k] <= (INIT_MODE == INIT_INDEX && k != 0) ? DATA_W'(k) : '0;
         end
      end else if (wb_we) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.sb_err <= 1'b0;
      end else if (wb_err) begin
         bus.sb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips32_regbank_sb.sv
// Directed bench for mips32_regbank_sb: reset contents, bypass, dependent issue, counter limits, flush, async reset.
module tb_mips32_regbank_sb;
   import mips32_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 32;
   localparam int unsigned RP = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mips32_regbank_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .RD_PORTS(RP)) ifc ();

   mips32_regbank_sb #(
      .DATA_W(DW), .NUM_REGS(NR), .RD_PORTS(RP), .CNT_W(2), .INIT_MODE(INIT_INDEX)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rdp(input int p);
      return ifc.rs_data[p*DW +: DW];
   endfunction

   task automatic idle();
      ifc.rs_addr     = '0;
      ifc.issue_valid = 1'b0;
      ifc.issue_rd_en = 1'b0;
      ifc.issue_rd    = '0;
      ifc.wb_valid    = 1'b0;
      ifc.wb_rd       = '0;
      ifc.wb_data     = '0;
      ifc.flush       = 1'b0;
   endtask

   task automatic issue(input reg_addr_t rd, input reg_addr_t ra, input reg_addr_t rb);
      ifc.issue_valid = 1'b1;
      ifc.issue_rd_en = 1'b1;
      ifc.issue_rd    = rd;
      ifc.rs_addr     = {rb, ra};
   endtask

   task automatic wb(input reg_addr_t rd, input logic [DW-1:0] d);
      ifc.wb_valid = 1'b1;
      ifc.wb_rd    = rd;
      ifc.wb_data  = d;
   endtask

   typedef struct {
      int rd;
      int ra;
      int rb;
      int imm;
   } instr_t;

   instr_t          prog [5];
   logic            p_v   [3];
   reg_addr_t       p_rd  [3];
   logic [DW-1:0]   p_dat [3];

   initial begin
      int            pc;
      int            cyc;
      int            stalls;
      logic          acc;
      logic [DW-1:0] res;

      idle();
      #12 reset = 1'b0;

      // 1: reset contents
      @(negedge clk);
      ifc.rs_addr = {5'd5, 5'd3};
      #1;
      chk("rst_read_53", ifc.rs_data, {32'd5, 32'd3});
      ifc.rs_addr = {5'd0, 5'd7};
      #1;
      chk("rst_read_r0", ifc.rs_data, {32'd0, 32'd7});
      chk("rst_busy", 64'(ifc.busy_vec), 64'd0);
      chk("rst_err", 64'(ifc.sb_err), 64'd0);
      chk("rst_stall", 64'(ifc.stall), 64'd0);

      // 2: single producer, bypass on writeback
      @(negedge clk);
      idle();
      issue(5'd1, 5'd0, 5'd0);
      #1 chk("t2_issue_ok", 64'(ifc.stall), 64'd0);
      @(negedge clk);
      idle();
      ifc.issue_valid = 1'b1;
      ifc.rs_addr     = {5'd0, 5'd1};
      #1;
      chk("t2_raw_stall", 64'(ifc.stall), 64'd1);
      chk("t2_busy1", 64'(ifc.busy_vec), 64'h2);
      wb(5'd1, 32'd10);
      #1;
      chk("t2_bypass", 64'(rdp(0)), 64'd10);
      chk("t2_bypass_nostall", 64'(ifc.stall), 64'd0);
      @(negedge clk);
      idle();
      ifc.rs_addr = {5'd0, 5'd1};
      #1;
      chk("t2_busy_clear", 64'(ifc.busy_vec), 64'd0);
      chk("t2_r1", 64'(rdp(0)), 64'd10);

      // 3: dependent chain with a 3-stage producer pipeline, no fillers
      prog[0] = '{rd: 1, ra: 0, rb: 0, imm: 10};
      prog[1] = '{rd: 2, ra: 0, rb: 0, imm: 20};
      prog[2] = '{rd: 3, ra: 0, rb: 0, imm: 25};
      prog[3] = '{rd: 4, ra: 1, rb: 2, imm: 0};
      prog[4] = '{rd: 5, ra: 4, rb: 3, imm: 0};
      for (int i = 0; i < 3; i++) begin
         p_v[i] = 1'b0; p_rd[i] = '0; p_dat[i] = '0;
      end
      pc = 0; cyc = 0; stalls = 0;
      while ((pc < 5 || p_v[0] || p_v[1] || p_v[2]) && cyc < 60) begin
         @(negedge clk);
         idle();
         if (p_v[2]) wb(p_rd[2], p_dat[2]);
         if (pc < 5) issue(5'(prog[pc].rd), 5'(prog[pc].ra), 5'(prog[pc].rb));
         #1;
         acc = (pc < 5) && !ifc.stall;
         if (pc < 5 && ifc.stall) stalls++;
         res = rdp(0) + rdp(1) + 32'(prog[(pc < 5) ? pc : 0].imm);
         @(posedge clk);
         p_v[2] = p_v[1]; p_rd[2] = p_rd[1]; p_dat[2] = p_dat[1];
         p_v[1] = p_v[0]; p_rd[1] = p_rd[0]; p_dat[1] = p_dat[0];
         p_v[0] = acc;
         p_rd[0] = acc ? 5'(prog[pc].rd) : 5'd0;
         p_dat[0] = res;
         if (acc) pc++;
         cyc++;
      end
      chk("t3_done_in_budget", 64'(cyc < 60), 64'd1);
      chk("t3_stall_count", 64'(stalls), 64'd3);
      @(negedge clk);
      idle();
      ifc.rs_addr = {5'd5, 5'd4};
      #1;
      chk("t3_r4_r5", ifc.rs_data, {32'd55, 32'd30});
      chk("t3_busy", 64'(ifc.busy_vec), 64'd0);
      chk("t3_err", 64'(ifc.sb_err), 64'd0);

      // 4: counter saturation on R7
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle();
         issue(5'd7, 5'd0, 5'd0);
         #1 chk($sformatf("t4_issue%0d", i), 64'(ifc.stall), 64'd0);
      end
      @(negedge clk);
      idle();
      issue(5'd7, 5'd0, 5'd0);
      #1;
      chk("t4_full_stall", 64'(ifc.stall), 64'd1);
      wb(5'd7, 32'd77);
      #1;
      chk("t4_full_wb_ok", 64'(ifc.stall), 64'd0);
      @(negedge clk);
      idle();
      issue(5'd7, 5'd0, 5'd0);
      #1 chk("t4_still_full", 64'(ifc.stall), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle();
         wb(5'd7, 32'(100 + i));
      end
      @(negedge clk);
      idle();
      ifc.rs_addr = {5'd0, 5'd7};
      #1;
      chk("t4_drained", 64'(ifc.busy_vec), 64'd0);
      chk("t4_r7", 64'(rdp(0)), 64'd102);
      chk("t4_err", 64'(ifc.sb_err), 64'd0);

      // 5: flush, then an orphan writeback
      issue(5'd4, 5'd0, 5'd0);
      @(negedge clk);
      issue(5'd6, 5'd0, 5'd0);
      @(negedge clk);
      idle();
      #1 chk("t5_busy46", 64'(ifc.busy_vec), 64'h50);
      ifc.flush = 1'b1;
      @(negedge clk);
      idle();
      #1 chk("t5_flushed", 64'(ifc.busy_vec), 64'd0);
      wb(5'd4, 32'd99);
      #1 chk("t5_err_pre", 64'(ifc.sb_err), 64'd0);
      @(negedge clk);
      idle();
      ifc.rs_addr = {5'd0, 5'd4};
      #1;
      chk("t5_err_set", 64'(ifc.sb_err), 64'd1);
      chk("t5_r4_kept", 64'(rdp(0)), 64'd30);
      @(negedge clk);
      #1 chk("t5_err_sticky", 64'(ifc.sb_err), 64'd1);

      // 6: async reset mid-stream
      @(negedge clk);
      idle();
      issue(5'd2, 5'd0, 5'd0);
      @(negedge clk);
      issue(5'd2, 5'd0, 5'd0);
      @(negedge clk);
      idle();
      ifc.issue_valid = 1'b1;
      ifc.rs_addr     = {5'd4, 5'd2};
      #1 chk("t6_pre_stall", 64'(ifc.stall), 64'd1);
      reset = 1'b1;
      #1;
      chk("t6_busy", 64'(ifc.busy_vec), 64'd0);
      chk("t6_stall", 64'(ifc.stall), 64'd0);
      chk("t6_regs", ifc.rs_data, {32'd4, 32'd2});
      chk("t6_err", 64'(ifc.sb_err), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
